// File: rtl/subkey_word_sequencer_if.sv
//==============================================================================
// Module      : subkey_word_sequencer_if
// Description : Handshake bundle between the round controller, the subkey
//               word sequencer and the downstream demux/subkey adder.
//               master : the environment side (drives start/subkey/ready)
//               slave  : the sequencer side (drives the word outputs)
//               Signals: start_i, subkey_num_i[4:0], ready_i,
//                        busy_o, valid_o, select_o[3:0], key_idx_o[4:0],
//                        tweak_idx_o[1:0], subkey_count_o[4:0], done_o, err_o
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface subkey_word_sequencer_if;
    logic       start_i;
    logic [4:0] subkey_num_i;
    logic       ready_i;
    logic       busy_o;
    logic       valid_o;
    logic [3:0] select_o;
    logic [4:0] key_idx_o;
    logic [1:0] tweak_idx_o;
    logic [4:0] subkey_count_o;
    logic       done_o;
    logic       err_o;

    modport master (
        output start_i, subkey_num_i, ready_i,
        input  busy_o, valid_o, select_o, key_idx_o, tweak_idx_o,
               subkey_count_o, done_o, err_o
    );

    modport slave (
        input  start_i, subkey_num_i, ready_i,
        output busy_o, valid_o, select_o, key_idx_o, tweak_idx_o,
               subkey_count_o, done_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/subkey_word_sequencer.sv
//==============================================================================
// Module      : subkey_word_sequencer
// Description : Walks the 16 word slots of one Threefish-1024 subkey
//               injection, one word per accepted cycle, producing the demux
//               word select, the extended-key index, the tweak index and the
//               subkey counter for the adder datapath.
// Ports       : clk_i  - clock, rising edge
//               rst_i  - synchronous active-high reset
//               bus    - subkey_word_sequencer_if.slave handshake bundle
// Parameters  : NUM_SUBKEYS - subkeys per block (legal s = 0..NUM_SUBKEYS-1)
//               KEY_WORDS   - extended-key words; key index wraps modulo this
// Options     : SUBKEY_SEQ_AUTO_INC_EN - s comes from an internal counter that
//               advances on each completed pass; subkey_num_i is unused and
//               err_o is tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module subkey_word_sequencer #(
    parameter int NUM_SUBKEYS = 21,
    parameter int KEY_WORDS   = 17
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_i,
    subkey_word_sequencer_if.slave       bus
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0] r_state;
    logic [3:0] r_i;
    logic [4:0] r_key_idx;
    logic [4:0] r_s;
    logic [1:0] r_s_mod3;
    logic       r_done;
    logic       r_err;

    logic [4:0] w_s;
    logic       w_s_ok;
    logic [4:0] w_s_mod_kw;
    logic [1:0] w_s_mod3;
    logic [1:0] w_tweak;
    logic       w_last;

`ifdef SUBKEY_SEQ_AUTO_INC_EN
    logic [4:0] r_auto_s;
    logic       w_unused_subkey_num;

    assign w_unused_subkey_num = ^bus.subkey_num_i;
    assign w_s                 = r_auto_s;
    // The counter never leaves 0..NUM_SUBKEYS-1, so every start is legal.
    assign w_s_ok              = 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_auto_s <= 5'd0;
        end else if (r_state == c_RUN && bus.ready_i && w_last) begin
            r_auto_s <= (r_auto_s == 5'(NUM_SUBKEYS - 1)) ? 5'd0 : r_auto_s + 5'd1;
        end
    end
`else
    assign w_s    = bus.subkey_num_i;
    assign w_s_ok = (32'(w_s) < NUM_SUBKEYS);
`endif

    // Constant-divisor reductions, evaluated only once per pass at load time.
    assign w_s_mod_kw = 5'(32'(w_s) % KEY_WORDS);
    assign w_s_mod3   = 2'(32'(w_s) % 3);
    assign w_last     = (r_i == 4'd15);

    // Word 13 carries tweak s mod 3, word 14 carries (s+1) mod 3.
    always_comb begin
        w_tweak = 2'd0;
        if (r_i == 4'd13) begin
            w_tweak = r_s_mod3;
        end else if (r_i == 4'd14) begin
            w_tweak = (r_s_mod3 == 2'd2) ? 2'd0 : r_s_mod3 + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_IDLE;
            r_i       <= 4'd0;
            r_key_idx <= 5'd0;
            r_s       <= 5'd0;
            r_s_mod3  <= 2'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start_i) begin
                        if (w_s_ok) begin
                            r_state   <= c_RUN;
                            r_i       <= 4'd0;
                            r_key_idx <= w_s_mod_kw;
                            r_s_mod3  <= w_s_mod3;
                            r_s       <= w_s;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    // start_i is deliberately not looked at here.
                    if (bus.ready_i) begin
                        if (w_last) begin
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
                            r_i     <= 4'd0;
                        end else begin
                            r_i       <= r_i + 4'd1;
                            r_key_idx <= (r_key_idx == 5'(KEY_WORDS - 1)) ? 5'd0
                                                                         : r_key_idx + 5'd1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.busy_o         = (r_state == c_RUN);
    assign bus.valid_o        = (r_state == c_RUN);
    assign bus.select_o       = r_i;
    assign bus.key_idx_o      = r_key_idx;
    assign bus.tweak_idx_o    = w_tweak;
    assign bus.subkey_count_o = r_s;
    assign bus.done_o         = r_done;
`ifdef SUBKEY_SEQ_AUTO_INC_EN
    assign bus.err_o          = 1'b0;
    logic w_unused_err;
    assign w_unused_err       = r_err;
`else
    assign bus.err_o          = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_subkey_word_sequencer.sv
//==============================================================================
// Module      : tb_subkey_word_sequencer
// Description : Scoreboard bench for subkey_word_sequencer. Stimulus pushes
//               expected word/done/err events; a negedge monitor pops and
//               compares whenever the sequencer presents one.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_subkey_word_sequencer;

    localparam int c_KW = 17;

    typedef enum logic [1:0] {K_WORD, K_DONE, K_ERR} kind_t;
    typedef struct {
        kind_t    kind;
        int       sel;
        int       key;
        int       tw;
        int       cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   hs_count;
    exp_t sb[$];

    subkey_word_sequencer_if bus();

    subkey_word_sequencer #(
        .NUM_SUBKEYS(21),
        .KEY_WORDS  (17)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word stream of one pass for subkey s.
    task automatic push_words(input int s, input int last_i);
        exp_t e;
        for (int i = 0; i <= last_i; i++) begin
            e.kind = K_WORD;
            e.sel  = i;
            e.key  = (s + i) % c_KW;
            e.tw   = (i == 13) ? (s % 3) : (i == 14) ? ((s + 1) % 3) : 0;
            e.cnt  = s;
            sb.push_back(e);
        end
    endtask

    task automatic push_pass(input int s);
        exp_t e;
        push_words(s, 15);
        e = '{K_DONE, 0, 0, 0, 0};
        sb.push_back(e);
    endtask

    task automatic start_pulse(input int s);
        bus.start_i      = 1'b1;
        bus.subkey_num_i = 5'(s);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    // Monitor / scoreboard
    logic        stall_prev;
    logic [20:0] snap;
    logic [20:0] cur;

    task automatic pop_cmp(input kind_t k);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event_kind", longint'(k), 64'hFF);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", longint'(k), longint'(e.kind));
        if (k == K_WORD && e.kind == K_WORD) begin
            chk("word_sel_key_tw_cnt",
                {bus.select_o, bus.key_idx_o, bus.tweak_idx_o, bus.subkey_count_o},
                {4'(e.sel), 5'(e.key), 2'(e.tw), 5'(e.cnt)});
        end
    endtask

    always @(negedge clk) begin
        cur = {bus.select_o, bus.key_idx_o, bus.tweak_idx_o, bus.subkey_count_o,
               bus.valid_o, bus.busy_o, bus.done_o, bus.err_o, 1'b0};
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && bus.valid_o) chk("hold_while_stalled", cur, snap);
            stall_prev = bus.valid_o && !bus.ready_i;
            snap       = cur;
            if (bus.valid_o && bus.ready_i) begin
                hs_count++;
                pop_cmp(K_WORD);
            end
            if (bus.done_o) pop_cmp(K_DONE);
            if (bus.err_o)  pop_cmp(K_ERR);
        end
    end

    // Counts negedges (starting from 1 = first word cycle) until done_o.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.done_o && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done_o) chk("done_timeout", 0, 1);
    endtask

    int   cyc;
    exp_t e_err;
    logic pulsed;

    initial begin
        checks = 0; errors = 0; hs_count = 0;
        stall_prev = 1'b0; snap = '0; cur = '0;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.subkey_num_i = 5'd0; bus.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_outputs",
            {bus.busy_o, bus.valid_o, bus.select_o, bus.key_idx_o, bus.tweak_idx_o,
             bus.subkey_count_o, bus.done_o, bus.err_o}, 0);

        // 1: s=0, ready high, latency and 17-cycle done
        @(posedge clk); #1;
        push_pass(0);
        start_pulse(0);
        @(negedge clk);
        chk("first_word_latency", {bus.valid_o, bus.busy_o, bus.select_o}, {2'b11, 4'd0});
        wait_done(cyc);
        chk("done_cycle_s0", cyc, 17);

        // 2: s=5, key index wraps 16 -> 0
        @(posedge clk); #1;
        push_pass(5);
        start_pulse(5);
        @(negedge clk);
        wait_done(cyc);
        chk("done_cycle_s5", cyc, 17);

        // 3: s=20, ready pattern 1,0,0,1
        @(posedge clk); #1;
        hs_count = 0;
        push_pass(20);
        start_pulse(20);
        begin
            int k;
            k = 0;
            while (!bus.done_o && k < 300) begin
                bus.ready_i = (k % 4 == 0 || k % 4 == 3);
                @(posedge clk); #1;
                k++;
            end
            chk("toggle_pass_done_seen", bus.done_o, 1);
        end
        bus.ready_i = 1'b1;
        chk("toggle_handshakes", hs_count, 16);

        // 4: out-of-range subkeys rejected
        @(posedge clk); #1;
        e_err = '{K_ERR, 0, 0, 0, 0};
        sb.push_back(e_err);
        start_pulse(21);
        repeat (3) begin
            @(negedge clk);
            chk("busy_after_s21", {bus.busy_o, bus.valid_o}, 0);
        end
        @(posedge clk); #1;
        sb.push_back(e_err);
        start_pulse(31);
        @(negedge clk);
        chk("busy_after_s31", {bus.busy_o, bus.err_o}, 2'b01);

        // 5: start during RUN ignored, reset at i=7 aborts without done
        @(posedge clk); #1;
        push_words(3, 7);
        start_pulse(3);
        pulsed = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.select_o == 4'd2 && !pulsed) begin
                #1;
                bus.start_i = 1'b1; bus.subkey_num_i = 5'd9;
                pulsed = 1'b1;
            end else begin
                #1 bus.start_i = 1'b0;
            end
        end while (bus.select_o != 4'd7 && cyc < 100);
        chk("reached_i7", bus.select_o, 7);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs",
            {bus.busy_o, bus.valid_o, bus.select_o, bus.key_idx_o, bus.tweak_idx_o,
             bus.subkey_count_o, bus.done_o, bus.err_o}, 0);
        repeat (20) @(negedge clk);
        chk("no_pass_after_reset", bus.busy_o, 0);

        // 6: back-to-back pass started in the done cycle
        @(posedge clk); #1;
        push_pass(7);
        start_pulse(7);
        @(negedge clk);
        wait_done(cyc);
        chk("done_cycle_s7", cyc, 17);
        #1;
        push_pass(12);
        bus.start_i = 1'b1; bus.subkey_num_i = 5'd12;
        @(posedge clk); #1 bus.start_i = 1'b0;
        @(negedge clk);
        chk("back_to_back_first", {bus.valid_o, bus.select_o, bus.subkey_count_o},
            {1'b1, 4'd0, 5'd12});
        wait_done(cyc);
        chk("done_cycle_s12", cyc, 17);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=0", 1);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
